uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that funnels NUM_REQ byte streams into one uart_tx.
// Ownership is held from grant until the owner's last byte or a stall timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [NUM_REQ*8-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_ready_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   timeout_o
);

    localparam int         IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] STALL_MAX   = 8'hFF;
    localparam logic [7:0] TIMEOUT_CNT = 8'(IDLE_TIMEOUT);
    localparam bit         TIMEOUT_EN  = (IDLE_TIMEOUT != 0);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       r_rr_ptr;
    logic [NUM_REQ-1:0]  r_grant;
    logic [7:0]          r_stall_cnt;
    logic                r_timeout;

    logic [IW-1:0]       w_pick;
    logic                w_pick_vld;
    logic [IW-1:0]       w_arb_idx;
    logic [IW-1:0]       w_owner_inc;
    logic                w_owner_vld;
    logic                w_xfer;
    logic                w_last_xfer;
    logic                w_timeout_fire;
    logic                w_release;

    // First valid requester at or above r_rr_ptr, wrapping around.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_arb_idx  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_arb_idx = IW'((32'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_pick_vld && req_valid_i[w_arb_idx]) begin
                w_pick     = w_arb_idx;
                w_pick_vld = 1'b1;
            end
        end
    end

    assign w_owner_vld    = req_valid_i[r_owner];
    assign w_owner_inc    = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_xfer         = (r_state == ST_LOCKED) && w_owner_vld && tx_ready_i;
    assign w_last_xfer    = w_xfer && req_last_i[r_owner];
    assign w_timeout_fire = TIMEOUT_EN && (r_state == ST_LOCKED) && (r_stall_cnt == TIMEOUT_CNT);
    assign w_release      = w_timeout_fire || w_last_xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
        if (r_state == ST_LOCKED) begin
            tx_valid_o           = w_owner_vld;
            req_ready_o[r_owner] = tx_ready_i;
            if (w_owner_vld) begin
                tx_data_o = req_data_i[r_owner*8 +: 8];
            end
        end
    end

    // Timeout wins over a same-cycle transfer: the lock is released either way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_timeout_fire;
            if (r_state == ST_IDLE) begin
                r_stall_cnt <= '0;
                if (w_pick_vld) begin
                    r_owner <= w_pick;
                    r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
                end
            end else if (w_release) begin
                r_grant     <= '0;
                r_rr_ptr    <= w_owner_inc;
                r_stall_cnt <= '0;
            end else if (w_xfer) begin
                r_stall_cnt <= '0;
            end else if (!w_owner_vld && (r_stall_cnt != STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end
    end

    assign grant_o   = r_grant;
    assign timeout_o = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, each cycle
// compared against an integer-level model of the arbitration rules.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   vld = '0;
    logic [N*8-1:0] dat = '0;
    logic [N-1:0]   lst = '0;
    logic           txr = 1'b0;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic [N-1:0]   grant;
    logic           timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .IDLE_TIMEOUT (TO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (vld),
        .req_data_i  (dat),
        .req_last_i  (lst),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (txr),
        .grant_o     (grant),
        .timeout_o   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 = idle), round-robin pointer, stall count.
    int m_own   = -1;
    int m_ptr   = 0;
    int m_stall = 0;
    bit m_to    = 1'b0;

    logic [N-1:0] obs_grant, obs_ready;
    logic         obs_valid, obs_timeout;
    logic [7:0]   obs_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own   = -1;
        m_ptr   = 0;
        m_stall = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge();
        bit xf;
        bit found;
        if (rst) begin
            model_reset();
        end else if (m_own < 0) begin
            m_to    = 1'b0;
            m_stall = 0;
            found   = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!found && vld[(m_ptr + i) % N]) begin
                    m_own = (m_ptr + i) % N;
                    found = 1'b1;
                end
            end
        end else begin
            xf = vld[m_own] && txr;
            if (TO != 0 && m_stall == TO) begin
                m_to    = 1'b1;
                m_ptr   = (m_own + 1) % N;
                m_own   = -1;
                m_stall = 0;
            end else if (xf && lst[m_own]) begin
                m_to    = 1'b0;
                m_ptr   = (m_own + 1) % N;
                m_own   = -1;
                m_stall = 0;
            end else begin
                m_to = 1'b0;
                if (xf) m_stall = 0;
                else if (!vld[m_own] && m_stall < 255) m_stall = m_stall + 1;
            end
        end
    endtask

    task automatic model_compare();
        logic [N-1:0] e_grant, e_ready;
        logic         e_valid;
        logic [7:0]   e_data;
        e_grant = '0;
        e_ready = '0;
        e_valid = 1'b0;
        e_data  = 8'h00;
        if (m_own >= 0) begin
            e_grant = N'(1) << m_own;
            e_valid = vld[m_own];
            if (e_valid) e_data = dat[m_own*8 +: 8];
            if (txr) e_ready = N'(1) << m_own;
        end
        check("grant",     32'(grant),     32'(e_grant));
        check("tx_valid",  32'(tx_valid),  32'(e_valid));
        check("tx_data",   32'(tx_data),   32'(e_data));
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("timeout",   32'(timeout),   32'(m_to));
    endtask

    // One clock: compare mid-cycle, then advance the model on the edge.
    task automatic step();
        @(negedge clk);
        if (rst) model_reset();
        obs_grant   = grant;
        obs_ready   = req_ready;
        obs_valid   = tx_valid;
        obs_data    = tx_data;
        obs_timeout = timeout;
        model_compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_byte(input int k, input logic [7:0] b);
        dat[k*8 +: 8] = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},   32'(grant),     32'd0);
        check({tag, "_valid"},   32'(tx_valid),  32'd0);
        check({tag, "_data"},    32'(tx_data),   32'd0);
        check({tag, "_ready"},   32'(req_ready), 32'd0);
        check({tag, "_timeout"}, 32'(timeout),   32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vld = '0;
        lst = '0;
        #1;
        check_all_zero("rst");
        model_reset();
        step();
        step();
        rst = 1'b0;
    endtask

    logic [N-1:0] rr_seq [8];
    bit           to_seen;
    int           pv, pr;

    initial begin
        // Single requester, three-byte packet
        do_reset();
        vld = 4'b0010; set_byte(1, 8'h48); lst = '0; txr = 1'b1;
        step();
        check("r029_pre_grant", 32'(obs_grant), 32'd0);
        step();
        check("r029_grant", 32'(obs_grant), 32'b0010);
        check("r029_b0", 32'(obs_data), 32'h48);
        set_byte(1, 8'h69);
        step();
        check("r029_b1", 32'(obs_data), 32'h69);
        check("r029_ready", 32'(obs_ready), 32'b0010);
        set_byte(1, 8'h0A); lst = 4'b0010;
        step();
        check("r029_b2", 32'(obs_data), 32'h0A);
        vld = '0; lst = '0;
        step();
        check("r029_release", 32'(obs_grant), 32'd0);

        // Round robin between requesters 0 and 2, one-byte packets
        do_reset();
        rr_seq = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 4'b0001, 4'b0000, 4'b0100};
        vld = 4'b0101; lst = 4'b0101; set_byte(0, 8'hA0); set_byte(2, 8'hC2); txr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("r030_seq", 32'(obs_grant), 32'(rr_seq[i]));
        end
        vld = '0; lst = '0;
        step();

        // Lock held against a competing requester
        do_reset();
        vld = 4'b1000; set_byte(3, 8'h33); lst = '0; txr = 1'b1;
        step();
        step();
        check("r031_grant3", 32'(obs_grant), 32'b1000);
        vld = 4'b1001; set_byte(0, 8'h44); lst = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            check("r031_lock", 32'(obs_ready[0]), 32'd0);
        end
        lst = 4'b1001;
        step();
        check("r031_last3", 32'(obs_ready), 32'b1000);
        vld = 4'b0001;
        step();
        check("r031_bubble", 32'(obs_grant), 32'd0);
        step();
        check("r031_grant0", 32'(obs_grant), 32'b0001);
        check("r031_ready0", 32'(obs_ready), 32'b0001);
        vld = '0; lst = '0;
        step();

        // Long back-pressure must not count as stall
        do_reset();
        vld = 4'b0100; set_byte(2, 8'h5A); lst = '0; txr = 1'b0;
        step();
        to_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            to_seen |= obs_timeout;
        end
        check("r032_no_timeout", 32'(to_seen), 32'd0);
        check("r032_grant", 32'(obs_grant), 32'b0100);
        check("r032_data", 32'(obs_data), 32'h5A);
        txr = 1'b1; lst = 4'b0100;
        step();
        vld = '0; lst = '0;
        step();

        // Owner stalls after first byte; timeout hands over to requester 2
        do_reset();
        vld = 4'b0001; set_byte(0, 8'h11); lst = '0; txr = 1'b1;
        step();
        step();
        vld = 4'b0100; set_byte(2, 8'h22); lst = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            step();
            check("r033_quiet", 32'(obs_timeout), 32'd0);
            check("r033_held", 32'(obs_grant), 32'b0001);
        end
        step();
        check("r033_pulse", 32'(obs_timeout), 32'd1);
        check("r033_idle", 32'(obs_grant), 32'd0);
        step();
        check("r033_pulse_end", 32'(obs_timeout), 32'd0);
        check("r033_next", 32'(obs_grant), 32'b0100);
        vld = '0; lst = '0;
        step();

        // Reset mid-packet, arbitration restarts at requester 0
        do_reset();
        vld = 4'b0010; set_byte(1, 8'h01); lst = 4'b0010; txr = 1'b1;
        step();
        step();
        vld = 4'b0100; lst = '0; set_byte(2, 8'hB1);
        step();
        step();
        check("r034_grant2", 32'(obs_grant), 32'b0100);
        set_byte(2, 8'hB2);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("r034_async");
        model_reset();
        vld = 4'b1001; lst = 4'b1001;
        step();
        step();
        rst = 1'b0;
        step();
        check("r034_bubble", 32'(obs_grant), 32'd0);
        step();
        check("r034_first", 32'(obs_grant), 32'b0001);
        vld = '0; lst = '0;
        step();

        // Random traffic with varying valid / ready densities
        for (int p = 0; p < 6; p++) begin
            pv = (p == 0) ? 90 : (p == 1) ? 70 : (p == 2) ? 50 : (p == 3) ? 25 : (p == 4) ? 95 : 60;
            pr = (p == 0) ? 80 : (p == 1) ? 50 : (p == 2) ? 90 : (p == 3) ? 70 : (p == 4) ? 30 : 60;
            for (int c = 0; c < 500; c++) begin
                for (int k = 0; k < N; k++) begin
                    vld[k] = ($urandom_range(99) < pv);
                    lst[k] = ($urandom_range(99) < 25);
                end
                dat = $urandom;
                txr = ($urandom_range(99) < pr);
                rst = ($urandom_range(999) < 3);
                step();
            end
        end
        rst = 1'b0;
        vld = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
